// File: rtl/synth_voice_scheduler.sv
// Polyphonic voice allocator feeding the synth tone FIFO load port.
// Optional build macro VOICE_STEAL_EN: steal the oldest voice instead of dropping a note-on when all voices are busy.
//
// state  | meaning
// IDLE   | ready for an event; a pending panic takes priority
// SEARCH | look up the latched event in the voice table, form the tone word
// EMIT   | hold the tone word until the synth can take it
// PANIC  | walk every voice, releasing the active ones
module synth_voice_scheduler #(
    parameter int VOICES = 4,
    parameter int AGE_W  = 8
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              ev_valid,
    output logic              ev_ready,
    input  logic              ev_on,
    input  logic [6:0]        ev_note,
    input  logic [6:0]        ev_vel,
    input  logic              all_off,
    input  logic              synth_run,
    input  logic              synth_fifo_full,
    output logic              synth_ld_fifo,
    output logic [31:0]       synth_tone,
    output logic [VOICES-1:0] voice_busy,
    output logic [15:0]       drop_count
);

    localparam int IDX_W = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VOICES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEARCH,
        S_EMIT,
        S_PANIC
    } state_t;

    state_t              state_q, state_d;
    logic [VOICES-1:0]   active_q;
    logic [6:0]          note_q [VOICES];
    logic [AGE_W-1:0]    age_q  [VOICES];
    logic                panic_pend_q;
    logic                in_panic_q;
    logic [IDX_W-1:0]    pan_idx_q;
    logic                ev_on_q;
    logic [6:0]          ev_note_q;
    logic [6:0]          ev_vel_q;
    logic [31:0]         tone_q;
    logic                ld_q;
    logic [15:0]         drop_q;

    logic                accept;
    logic                match_hit, free_hit;
    logic [IDX_W-1:0]    match_idx, free_idx;
    logic                alloc_en, clear_en, tone_load, drop_inc, emit_go;
    logic                pan_start, pan_step;
    logic [IDX_W-1:0]    alloc_idx, clear_idx;
    logic [31:0]         tone_d;

    function automatic logic [31:0] mk_tone(input logic gate, input logic [IDX_W-1:0] idx,
                                            input logic [6:0] n, input logic [6:0] v);
        return {gate, 7'b0, 8'(idx), 1'b0, n, 1'b0, v};
    endfunction

    assign ev_ready      = reset_reset_n & (state_q == S_IDLE) & ~panic_pend_q;
    assign accept        = ev_valid & ev_ready;
    assign synth_ld_fifo = ld_q;
    assign synth_tone    = tone_q;
    assign voice_busy    = active_q;
    assign drop_count    = drop_q;

    // Lowest-index hits: first matching active voice, first free voice.
    always_comb begin
        match_hit = 1'b0;
        match_idx = '0;
        free_hit  = 1'b0;
        free_idx  = '0;
        for (int i = 0; i < VOICES; i++) begin
            if (!match_hit && active_q[i] && (note_q[i] == ev_note_q)) begin
                match_hit = 1'b1;
                match_idx = IDX_W'(i);
            end
            if (!free_hit && !active_q[i]) begin
                free_hit = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

`ifdef VOICE_STEAL_EN
    logic [IDX_W-1:0] old_idx;
    logic [AGE_W-1:0] old_age;

    // Strictly-greater compare keeps the lowest index on ties.
    always_comb begin
        old_idx = '0;
        old_age = age_q[0];
        for (int i = 1; i < VOICES; i++) begin
            if (age_q[i] > old_age) begin
                old_age = age_q[i];
                old_idx = IDX_W'(i);
            end
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        alloc_en  = 1'b0;
        alloc_idx = '0;
        clear_en  = 1'b0;
        clear_idx = '0;
        tone_load = 1'b0;
        tone_d    = tone_q;
        drop_inc  = 1'b0;
        emit_go   = 1'b0;
        pan_start = 1'b0;
        pan_step  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (panic_pend_q) begin
                    pan_start = 1'b1;
                    state_d   = S_PANIC;
                end else if (accept) begin
                    state_d = S_SEARCH;
                end
            end
            S_SEARCH: begin
                if (ev_on_q) begin
                    if (match_hit) begin
                        alloc_en  = 1'b1;
                        alloc_idx = match_idx;
                    end else if (free_hit) begin
                        alloc_en  = 1'b1;
                        alloc_idx = free_idx;
                    end else begin
`ifdef VOICE_STEAL_EN
                        alloc_en  = 1'b1;
                        alloc_idx = old_idx;
`else
                        drop_inc  = 1'b1;
`endif
                    end
                    if (alloc_en) begin
                        tone_load = 1'b1;
                        tone_d    = mk_tone(1'b1, alloc_idx, ev_note_q, ev_vel_q);
                        state_d   = S_EMIT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (match_hit) begin
                    clear_en  = 1'b1;
                    clear_idx = match_idx;
                    tone_load = 1'b1;
                    tone_d    = mk_tone(1'b0, match_idx, ev_note_q, 7'd0);
                    state_d   = S_EMIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_EMIT: begin
                if (synth_run && !synth_fifo_full) begin
                    emit_go = 1'b1;
                    if (in_panic_q) begin
                        clear_en  = 1'b1;
                        clear_idx = pan_idx_q;
                        if (pan_idx_q == LAST_IDX) begin
                            state_d = S_IDLE;
                        end else begin
                            pan_step = 1'b1;
                            state_d  = S_PANIC;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_PANIC: begin
                if (active_q[pan_idx_q]) begin
                    tone_load = 1'b1;
                    tone_d    = mk_tone(1'b0, pan_idx_q, note_q[pan_idx_q], 7'd0);
                    state_d   = S_EMIT;
                end else if (pan_idx_q == LAST_IDX) begin
                    state_d = S_IDLE;
                end else begin
                    pan_step = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q      <= S_IDLE;
            panic_pend_q <= 1'b0;
            in_panic_q   <= 1'b0;
            pan_idx_q    <= '0;
            ev_on_q      <= 1'b0;
            ev_note_q    <= '0;
            ev_vel_q     <= '0;
            tone_q       <= '0;
            ld_q         <= 1'b0;
            drop_q       <= '0;
        end else begin
            state_q <= state_d;
            ld_q    <= emit_go;
            // A request arriving during the walk stays latched and is serviced afterwards.
            if (all_off) begin
                panic_pend_q <= 1'b1;
            end else if (pan_start) begin
                panic_pend_q <= 1'b0;
            end
            if (pan_start) begin
                in_panic_q <= 1'b1;
                pan_idx_q  <= '0;
            end else if (pan_step) begin
                pan_idx_q <= pan_idx_q + 1'b1;
            end
            if (accept) begin
                in_panic_q <= 1'b0;
                ev_on_q    <= ev_on;
                ev_note_q  <= ev_note;
                ev_vel_q   <= ev_vel;
            end
            if (tone_load) begin
                tone_q <= tone_d;
            end
            if (drop_inc && (drop_q != 16'hFFFF)) begin
                drop_q <= drop_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            active_q <= '0;
            for (int i = 0; i < VOICES; i++) begin
                note_q[i] <= '0;
                age_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < VOICES; i++) begin
                if (alloc_en && (alloc_idx == IDX_W'(i))) begin
                    active_q[i] <= 1'b1;
                    note_q[i]   <= ev_note_q;
                    age_q[i]    <= '0;
                end else if (alloc_en && active_q[i] && (age_q[i] != '1)) begin
                    age_q[i] <= age_q[i] + 1'b1;
                end
                if (clear_en && (clear_idx == IDX_W'(i))) begin
                    active_q[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_synth_voice_scheduler.sv
// Self-checking bench for synth_voice_scheduler: vector table plus backpressure, panic and reset sequences.
module tb_synth_voice_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ev_valid, ev_ready, ev_on, all_off, synth_run, synth_fifo_full;
    logic [6:0]  ev_note, ev_vel;
    logic        synth_ld_fifo;
    logic [31:0] synth_tone;
    logic [3:0]  voice_busy;
    logic [15:0] drop_count;

    int checks = 0;
    int passes = 0;
    int strobes = 0;
    logic prev_ld = 1'b0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    synth_voice_scheduler #(.VOICES(4), .AGE_W(8)) dut (
        .clk_clk(clk), .reset_reset_n(rst_n),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_on(ev_on),
        .ev_note(ev_note), .ev_vel(ev_vel), .all_off(all_off),
        .synth_run(synth_run), .synth_fifo_full(synth_fifo_full),
        .synth_ld_fifo(synth_ld_fifo), .synth_tone(synth_tone),
        .voice_busy(voice_busy), .drop_count(drop_count)
    );

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endfunction

    // Scoreboard: every strobe pops the oldest expected tone word.
    always @(negedge clk) begin
        if (synth_ld_fifo === 1'b1) begin
            strobes++;
            check("ld_not_back_to_back", {31'd0, prev_ld}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", synth_tone, 32'hFFFF_FFFF);
            end else begin
                check("tone", synth_tone, exp_q.pop_front());
            end
        end
        prev_ld = synth_ld_fifo;
    end

    typedef struct {
        logic        on;
        logic [6:0]  note;
        logic [6:0]  vel;
        logic        strobe;
        logic [31:0] tone;
        logic [3:0]  busy;
    } vec_t;

    vec_t vecs[11];

    task automatic send(input logic on, input logic [6:0] n, input logic [6:0] v);
        int w = 0;
        while (ev_ready !== 1'b1 && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        check("ev_ready_wait", {31'd0, ev_ready}, 32'd1);
        ev_valid = 1'b1; ev_on = on; ev_note = n; ev_vel = v;
        @(posedge clk); #1;
        ev_valid = 1'b0;
    endtask

    initial begin
        int s0, hi_cnt, w;
        logic l0, l1, l2;

        vecs[0]  = '{1'b1, 7'd60, 7'd100, 1'b1, 32'h80003C64, 4'b0001};
        vecs[1]  = '{1'b0, 7'd60, 7'd0,   1'b1, 32'h00003C00, 4'b0000};
        vecs[2]  = '{1'b0, 7'd61, 7'd0,   1'b0, 32'h0,        4'b0000};
        vecs[3]  = '{1'b1, 7'd60, 7'd100, 1'b1, 32'h80003C64, 4'b0001};
        vecs[4]  = '{1'b1, 7'd60, 7'd20,  1'b1, 32'h80003C14, 4'b0001};
        vecs[5]  = '{1'b1, 7'd62, 7'd100, 1'b1, 32'h80013E64, 4'b0011};
        vecs[6]  = '{1'b1, 7'd64, 7'd100, 1'b1, 32'h80024064, 4'b0111};
        vecs[7]  = '{1'b1, 7'd65, 7'd100, 1'b1, 32'h80034164, 4'b1111};
`ifdef VOICE_STEAL_EN
        vecs[8]  = '{1'b1, 7'd67, 7'd100, 1'b1, 32'h80004364, 4'b1111};
`else
        vecs[8]  = '{1'b1, 7'd67, 7'd100, 1'b0, 32'h0,        4'b1111};
`endif
        vecs[9]  = '{1'b0, 7'd62, 7'd0,   1'b1, 32'h00013E00, 4'b1101};
        vecs[10] = '{1'b0, 7'd65, 7'd0,   1'b1, 32'h00034100, 4'b0101};

        rst_n = 1'b0; ev_valid = 1'b0; ev_on = 1'b0; ev_note = '0; ev_vel = '0;
        all_off = 1'b0; synth_run = 1'b1; synth_fifo_full = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ev_ready", {31'd0, ev_ready}, 32'd0);
        check("rst_outputs", {synth_ld_fifo, 7'd0, voice_busy, 4'd0, drop_count}, 32'd0);
        check("rst_tone", synth_tone, 32'd0);
        rst_n = 1'b1;
        #1;
        check("ev_ready_after_rst", {31'd0, ev_ready}, 32'd1);
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) begin
            s0 = strobes;
            if (vecs[i].strobe) exp_q.push_back(vecs[i].tone);
            send(vecs[i].on, vecs[i].note, vecs[i].vel);
            l0 = synth_ld_fifo;
            @(posedge clk); #1; l1 = synth_ld_fifo;
            @(posedge clk); #1; l2 = synth_ld_fifo;
            check($sformatf("latency_v%0d", i), {29'd0, l0, l1, l2}, {29'd0, 2'b00, vecs[i].strobe});
            repeat (4) @(posedge clk);
            #1;
            check($sformatf("busy_v%0d", i), {28'd0, voice_busy}, {28'd0, vecs[i].busy});
            check($sformatf("strobes_v%0d", i), strobes - s0, {31'd0, vecs[i].strobe});
        end
`ifdef VOICE_STEAL_EN
        check("drop_count", {16'd0, drop_count}, 32'd0);
`else
        check("drop_count", {16'd0, drop_count}, 32'd1);
`endif

        // Panic with voices 0 and 2 active.
`ifdef VOICE_STEAL_EN
        exp_q.push_back(32'h00004300);
`else
        exp_q.push_back(32'h00003C00);
`endif
        exp_q.push_back(32'h00024000);
        s0 = strobes;
        all_off = 1'b1;
        @(posedge clk); #1;
        all_off = 1'b0;
        hi_cnt = 0; w = 0;
        while (strobes - s0 < 2 && w < 50) begin
            if (ev_ready) hi_cnt++;
            @(posedge clk); #1;
            w++;
        end
        check("panic_strobes", strobes - s0, 32'd2);
        check("panic_ev_ready_low", hi_cnt, 32'd0);
        w = 0;
        while (ev_ready !== 1'b1 && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        check("panic_busy", {28'd0, voice_busy}, 32'd0);

        // Backpressure via fifo_full, then via synth_run.
        for (int k = 0; k < 2; k++) begin
            if (k == 0) synth_fifo_full = 1'b1; else synth_run = 1'b0;
            exp_q.push_back(k == 0 ? 32'h80004864 : 32'h00004800);
            s0 = strobes;
            send(k == 0, 7'd72, k == 0 ? 7'd100 : 7'd0);
            hi_cnt = 0;
            for (int c = 0; c < 20; c++) begin
                if (synth_ld_fifo || ev_ready) hi_cnt++;
                @(posedge clk); #1;
            end
            check($sformatf("stall_quiet_%0d", k), hi_cnt, 32'd0);
            synth_fifo_full = 1'b0; synth_run = 1'b1;
            @(posedge clk); #1;
            check($sformatf("stall_release_%0d", k), {31'd0, synth_ld_fifo}, 32'd1);
            repeat (3) @(posedge clk);
            #1;
            check($sformatf("stall_strobes_%0d", k), strobes - s0, 32'd1);
        end

        // fifo_full rising in the EMIT check cycle.
        exp_q.push_back(32'h80005001);
        s0 = strobes;
        send(1'b1, 7'd80, 7'd1);
        @(posedge clk); #1;
        synth_fifo_full = 1'b1;
        @(posedge clk); #1;
        check("full_same_cycle", {31'd0, synth_ld_fifo}, 32'd0);
        synth_fifo_full = 1'b0;
        @(posedge clk); #1;
        check("full_same_cycle_release", {31'd0, synth_ld_fifo}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("full_same_cycle_strobes", strobes - s0, 32'd1);

        // Reset while a word waits in EMIT.
        synth_fifo_full = 1'b1;
        s0 = strobes;
        send(1'b1, 7'd60, 7'd100);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_ev_ready", {31'd0, ev_ready}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        synth_fifo_full = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("midrst_no_strobe", strobes - s0, 32'd0);
        check("midrst_outputs", {ev_ready, synth_ld_fifo, 6'd0, voice_busy, 4'd0, drop_count}, 32'h8000_0000);
        check("midrst_tone", synth_tone, 32'd0);
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
